mem_rr_arbiter: RTL and testbench
=================================

Name: mem_rr_arbiter

Overview:
- Round-robin arbiter sharing the single SoC memory bus (valid/instr/addr/wdata/wstrb/rdata/ready) among NREQ requesters: CPU instruction port, CPU data port, and future masters such as a debug or DMA port.
- Captures one-cycle request pulses, serialises them onto the memory bus, and routes each response back to its owner.
- A watchdog completes any transaction that no slave answers, so unmapped addresses cannot hang the core.

Parameters:
- NREQ, 3, number of requesters, legal range 2..8.
- TIMEOUT, 255, number of cycles in WAIT without memory_ready before the arbiter forces an error completion.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  NREQ  one-cycle request pulse per requester.
- req_instr  in  NREQ  instruction-fetch flag.
- req_addr  in  NREQ*32  byte address; requester i uses bits [32i+31:32i].
- req_wdata  in  NREQ*32  write data.
- req_wstrb  in  NREQ*4  byte strobes; all zero means read.
- req_rdata  out  NREQ*32  read data returned to each requester.
- req_ready  out  NREQ  one-cycle completion pulse.
- req_error  out  NREQ  timeout flag; valid only in the cycle req_ready is high.
- memory_valid  out  1  one-cycle request pulse to the decoder.
- memory_instr  out  1  forwarded instruction flag.
- memory_addr  out  32  forwarded address.
- memory_wdata  out  32  forwarded write data.
- memory_wstrb  out  4  forwarded strobes.
- memory_rdata  in  32  slave read data.
- memory_ready  in  1  slave completion.

Behaviour:
- Reset (reset==0 at a clock edge):
  - Outputs: all req_ready, req_error, req_rdata, memory_valid, memory_addr, memory_wdata, memory_wstrb and memory_instr go to 0.
  - State: pending bits clear, state=IDLE, rr pointer=0, timeout counter=0.
- Capture:
  - On req_valid[i], the payload of requester i is latched into slot i and pending[i] is set.
  - If pending[i] is already set, the new pulse is ignored; this is a protocol violation and no state changes.
- Pending clear: pending[i] clears on the edge at which its transaction completes. A req_valid[i] arriving in the same cycle as that completion is captured, because capture takes precedence over clear.
- Grant:
  - In IDLE, the first pending requester at or after rr pointer, searching upward modulo NREQ, is granted.
  - A request arriving in the current cycle is eligible, using combinational OR of req_valid and pending.
  - Next state is ISSUE.
  - rr pointer becomes (grant+1) mod NREQ.
- ISSUE:
  - memory_valid=1 for exactly one cycle, with the granted payload registered on the memory_* outputs.
  - memory_* payload holds stable until completion.
  - Next state is WAIT, and the counter is cleared.
- WAIT, memory_ready==1:
  - Registered return to the granted requester: req_rdata[g]=memory_rdata, req_ready[g]=1 and req_error[g]=0 in the next cycle.
  - Next state is IDLE.
  - A memory_ready arriving in the same cycle as ISSUE is also accepted.
- WAIT, no ready: the counter increments each cycle.
  - When the counter reaches TIMEOUT, the arbiter returns req_ready[g]=1, req_error[g]=1 and req_rdata[g]=0, then goes to IDLE.
  - A memory_ready arriving later is ignored.
- Stray ready: memory_ready outside ISSUE/WAIT is ignored.
- Latency: request pulse in cycle 0 gives memory_valid in cycle 1. A slave ready in cycle k gives req_ready in cycle k+1. Back-to-back requests cost at least 3 cycles each.
- req_rdata hold: req_rdata[i] holds its last value between completions.
- Other outputs: req_ready and req_error of every non-granted requester stay 0.
- Reset mid-transaction: everything is dropped with no response to the requester, and a late memory_ready after reset is ignored.
- Counter width: $clog2(TIMEOUT+1) bits; it never wraps.

Decomposition:
- Shared package (configure): arb_state_t enum {IDLE, ISSUE, WAIT} and a default timeout constant.
- Sub-module rr_pick:
  - Purely combinational.
  - Inputs: the request vector and the pointer.
  - Outputs: the grant index and a found flag.
- Top-level module: the capture slots, FSM, counter and return registers.

Test Plan:
- Single read: req_valid[0] with addr 0x0000_0100; slave returns ready with rdata 0xDEADBEEF 2 cycles after memory_valid. Required: memory_valid in cycle 1 with addr 0x100, then req_ready[0]=1 with req_rdata[0]=0xDEADBEEF and req_error[0]=0.
- Fairness: all three requesters pulse in the same cycle from reset. Required: grant order is 0,1,2; a second wave then yields order 0,1,2 again since the pointer has wrapped to 0.
- Write: req 1 with wdata 0x12345678 and wstrb 4'b0011. Required: memory_wdata=0x12345678 and memory_wstrb=0011 on the forwarded request, plus one req_ready[1] pulse.
- Timeout: TIMEOUT=8 and the slave never answers. Required: req_ready[2]=1 with req_error[2]=1 and rdata 0 at cycle 1+1+8+1 (counter reaches 8); a late memory_ready is ignored and the next request proceeds normally.
- Overlap: req 0 in progress while req 1 pulses. Required: req 1 is issued after req 0 completes. A duplicate req_valid[1] while pending[1] is set produces no extra transaction.
- Reset: drive reset=0 while in WAIT, then release it. Required: all outputs are 0, no req_ready appears, and a ready returned after reset has no effect.

Source files
------------

// File: rtl/mem_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin memory bus arbiter.
package mem_rr_arbiter_pkg;

  localparam int unsigned ADDR_W          = 32;
  localparam int unsigned DATA_W          = 32;
  localparam int unsigned STRB_W          = 4;
  localparam int unsigned DEFAULT_TIMEOUT = 255;

  typedef logic [1:0] arb_state_t;
  localparam arb_state_t IDLE  = 2'd0;
  localparam arb_state_t ISSUE = 2'd1;
  localparam arb_state_t WAIT  = 2'd2;

  typedef struct packed {
    logic              instr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } req_payload_t;

endpackage

// File: rtl/mem_rr_arbiter_if.sv
// Requester-side and memory-side bus bundle of the arbiter.
interface mem_rr_arbiter_if
  import mem_rr_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 3
) ();

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_instr;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ*STRB_W-1:0] req_wstrb;
  logic [NREQ*DATA_W-1:0] req_rdata;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        req_error;

  logic                   memory_valid;
  logic                   memory_instr;
  logic [ADDR_W-1:0]      memory_addr;
  logic [DATA_W-1:0]      memory_wdata;
  logic [STRB_W-1:0]      memory_wstrb;
  logic [DATA_W-1:0]      memory_rdata;
  logic                   memory_ready;

  // master: the arbiter itself; slave: requesters plus memory slave side
  modport master (
    input  req_valid, req_instr, req_addr, req_wdata, req_wstrb,
    input  memory_rdata, memory_ready,
    output req_rdata, req_ready, req_error,
    output memory_valid, memory_instr, memory_addr, memory_wdata, memory_wstrb
  );

  modport slave (
    output req_valid, req_instr, req_addr, req_wdata, req_wstrb,
    output memory_rdata, memory_ready,
    input  req_rdata, req_ready, req_error,
    input  memory_valid, memory_instr, memory_addr, memory_wdata, memory_wstrb
  );

endinterface

// File: rtl/mem_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, modulo NREQ.
module mem_rr_arbiter_rr_pick #(
  parameter  int unsigned NREQ = 3,
  localparam int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   grant_c,
  output logic            found_c
);

  logic [IW-1:0] idx;

  always_comb begin
    grant_c = '0;
    found_c = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = IW'((32'(ptr) + k) % NREQ);
      if (!found_c && req[idx]) begin
        found_c = 1'b1;
        grant_c = idx;
      end
    end
  end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter serialising captured requester pulses onto one memory bus,
// with a watchdog that error-completes transactions no slave answers.
module mem_rr_arbiter
  import mem_rr_arbiter_pkg::*;
#(
  parameter int unsigned NREQ    = 3,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input logic              clock,
  input logic              reset,
  mem_rr_arbiter_if.master bus
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  arb_state_t      state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d, gnt_q, grant_c;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            found_c, issue_c, done_c, timeout_c;
  logic [NREQ-1:0] pending_q, eligible_c, capture_c, release_c;
  req_payload_t    slot_q  [NREQ];
  req_payload_t    fresh_c [NREQ];
  req_payload_t    pick_c;

  // Per-requester capture: a pulse is taken unless the slot is busy and not being released
  for (genvar i = 0; i < NREQ; i++) begin : g_req
    assign fresh_c[i] = '{instr: bus.req_instr[i],
                          addr:  bus.req_addr [i*ADDR_W +: ADDR_W],
                          wdata: bus.req_wdata[i*DATA_W +: DATA_W],
                          wstrb: bus.req_wstrb[i*STRB_W +: STRB_W]};
    assign capture_c[i] = bus.req_valid[i] && (!pending_q[i] || release_c[i]);

    always_ff @(posedge clock) begin
      if (capture_c[i]) slot_q[i] <= fresh_c[i];
    end

    always_ff @(posedge clock) begin
      if (!reset) begin
        bus.req_rdata[i*DATA_W +: DATA_W] <= '0;
      end else if (release_c[i]) begin
        bus.req_rdata[i*DATA_W +: DATA_W] <= timeout_c ? '0 : bus.memory_rdata;
      end
    end
  end

  assign eligible_c = pending_q | bus.req_valid;
  assign pick_c     = pending_q[grant_c] ? slot_q[grant_c] : fresh_c[grant_c];

  mem_rr_arbiter_rr_pick #(.NREQ(NREQ)) u_pick (
    .req     (eligible_c),
    .ptr     (ptr_q),
    .grant_c (grant_c),
    .found_c (found_c)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    issue_c   = 1'b0;
    done_c    = 1'b0;
    timeout_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (found_c) begin
          issue_c = 1'b1;
          state_d = ISSUE;
          ptr_d   = (grant_c == IW'(NREQ - 1)) ? '0 : grant_c + IW'(1);
        end
      end
      ISSUE: begin
        if (bus.memory_ready) begin
          done_c  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (bus.memory_ready) begin
          done_c  = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          done_c    = 1'b1;
          timeout_c = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    release_c = '0;
    if (done_c) release_c[gnt_q] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      pending_q <= capture_c | (pending_q & ~release_c);
      if (issue_c) gnt_q <= grant_c;
    end
  end

  // Forwarded request: valid pulses once, payload holds until the next grant
  always_ff @(posedge clock) begin
    if (!reset) begin
      bus.memory_valid <= 1'b0;
      bus.memory_instr <= 1'b0;
      bus.memory_addr  <= '0;
      bus.memory_wdata <= '0;
      bus.memory_wstrb <= '0;
    end else begin
      bus.memory_valid <= issue_c;
      if (issue_c) begin
        bus.memory_instr <= pick_c.instr;
        bus.memory_addr  <= pick_c.addr;
        bus.memory_wdata <= pick_c.wdata;
        bus.memory_wstrb <= pick_c.wstrb;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      bus.req_ready <= '0;
      bus.req_error <= '0;
    end else begin
      bus.req_ready <= release_c;
      bus.req_error <= timeout_c ? release_c : '0;
    end
  end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Self-checking bench for mem_rr_arbiter: directed scenarios plus random traffic
// compared every cycle against a transaction-level model.
module tb_mem_rr_arbiter;
  import mem_rr_arbiter_pkg::*;

  localparam int unsigned N  = 3;
  localparam int unsigned TO = 8;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  mem_rr_arbiter_if #(.NREQ(N)) bus ();

  mem_rr_arbiter #(.NREQ(N), .TIMEOUT(TO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Model: pending slots, one outstanding transaction with its age since memory_valid
  bit          m_pend  [N];
  logic [31:0] m_addr  [N];
  logic [31:0] m_wdata [N];
  logic [3:0]  m_wstrb [N];
  bit          m_instr [N];
  bit          m_busy;
  int          m_owner, m_age, m_ptr;

  logic        e_mv, e_instr;
  logic [31:0] e_addr, e_wdata;
  logic [3:0]  e_wstrb;
  logic [N-1:0] e_ready, e_err;
  logic [31:0] e_rdata [N];

  bit          auto_ready, outstanding;
  logic [31:0] addr_log [$];
  int          ready_cnt [N];
  int          err_cnt;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %0h want %0h", name, cyc, act, exp);
    end
  endfunction

  task automatic model_step();
    bit done;
    bit tmo;
    int own;
    done = 1'b0;
    tmo  = 1'b0;
    if (!reset) begin
      m_busy = 0; m_owner = 0; m_age = 0; m_ptr = 0;
      e_mv = 0; e_instr = 0; e_addr = 0; e_wdata = 0; e_wstrb = 0;
      e_ready = '0; e_err = '0;
      for (int i = 0; i < N; i++) begin
        m_pend[i]  = 0;
        e_rdata[i] = '0;
      end
      return;
    end
    e_mv    = 0;
    e_ready = '0;
    e_err   = '0;
    own     = m_owner;
    if (m_busy) begin
      if (bus.memory_ready) done = 1'b1;
      else if (m_age == TO + 1) begin done = 1'b1; tmo = 1'b1; end
      else m_age++;
      if (done) begin
        m_busy       = 0;
        e_ready[own] = 1'b1;
        e_err[own]   = tmo;
        e_rdata[own] = tmo ? 32'h0 : bus.memory_rdata;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (!e_mv && (m_pend[j] || bus.req_valid[j])) begin
          e_mv = 1; m_owner = j; m_busy = 1; m_age = 0; m_ptr = (j + 1) % N;
          if (m_pend[j]) begin
            e_addr = m_addr[j]; e_wdata = m_wdata[j]; e_wstrb = m_wstrb[j]; e_instr = m_instr[j];
          end else begin
            e_addr  = bus.req_addr[32*j +: 32];
            e_wdata = bus.req_wdata[32*j +: 32];
            e_wstrb = bus.req_wstrb[4*j +: 4];
            e_instr = bus.req_instr[j];
          end
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (bus.req_valid[i] && (!m_pend[i] || (done && own == i))) begin
        m_pend[i]  = 1;
        m_addr[i]  = bus.req_addr[32*i +: 32];
        m_wdata[i] = bus.req_wdata[32*i +: 32];
        m_wstrb[i] = bus.req_wstrb[4*i +: 4];
        m_instr[i] = bus.req_instr[i];
      end else if (done && own == i) begin
        m_pend[i] = 0;
      end
    end
  endtask

  // One clock: predict, advance to the falling edge, compare, log events
  task automatic tick();
    if (auto_ready) bus.memory_ready = outstanding;
    model_step();
    @(negedge clock);
    cyc++;
    chk("memory_valid", bus.memory_valid, e_mv);
    chk("memory_addr",  bus.memory_addr,  e_addr);
    chk("memory_wdata", bus.memory_wdata, e_wdata);
    chk("memory_wstrb", bus.memory_wstrb, e_wstrb);
    chk("memory_instr", bus.memory_instr, e_instr);
    chk("req_ready",    bus.req_ready,    e_ready);
    chk("req_error",    bus.req_error,    e_err);
    for (int i = 0; i < N; i++)
      chk($sformatf("req_rdata[%0d]", i), bus.req_rdata[32*i +: 32], e_rdata[i]);
    if (!reset) outstanding = 0;
    for (int i = 0; i < N; i++) begin
      if (bus.req_ready[i]) begin
        ready_cnt[i]++;
        outstanding = 0;
        if (bus.req_error[i]) err_cnt++;
      end
    end
    if (bus.memory_valid) begin
      addr_log.push_back(bus.memory_addr);
      outstanding = 1;
    end
    bus.req_valid    = '0;
    bus.memory_ready = 1'b0;
  endtask

  task automatic clear_log();
    addr_log.delete();
    for (int i = 0; i < N; i++) ready_cnt[i] = 0;
    err_cnt = 0;
  endtask

  task automatic chk_log(string name, logic [31:0] e0, logic [31:0] e1, logic [31:0] e2, int n);
    logic [31:0] exp_a [3];
    exp_a[0] = e0; exp_a[1] = e1; exp_a[2] = e2;
    chk({name, " count"}, addr_log.size(), n);
    for (int k = 0; k < n; k++)
      chk($sformatf("%s order[%0d]", name, k), (k < addr_log.size()) ? addr_log[k] : 32'hFFFF_FFFF, exp_a[k]);
  endtask

  initial begin
    int c;
    bit found;
    reset = 1'b0;
    bus.req_valid = '0; bus.req_instr = '0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_wstrb = '0;
    bus.memory_ready = 1'b0; bus.memory_rdata = 32'hCAFE_0000;
    auto_ready = 1; outstanding = 0;
    clear_log();

    // Reset state
    tick(); tick();
    chk("reset memory_valid", bus.memory_valid, 1'b0);
    chk("reset memory_addr",  bus.memory_addr, 32'h0);
    chk("reset req_ready",    bus.req_ready, 3'b000);
    chk("reset req_rdata",    bus.req_rdata, 96'h0);
    reset = 1'b1;
    tick();

    // Single read
    auto_ready = 0;
    bus.req_valid = 3'b001; bus.req_addr[31:0] = 32'h0000_0100;
    tick();
    chk("read mv",   bus.memory_valid, 1'b1);
    chk("read addr", bus.memory_addr, 32'h100);
    tick(); tick();
    bus.memory_ready = 1'b1; bus.memory_rdata = 32'hDEAD_BEEF;
    tick();
    chk("read ready", bus.req_ready, 3'b001);
    chk("read rdata", bus.req_rdata[31:0], 32'hDEAD_BEEF);
    chk("read error", bus.req_error, 3'b000);
    bus.memory_rdata = 32'hCAFE_0000;

    // Fairness: two full waves from reset
    auto_ready = 1;
    reset = 1'b0; tick(); reset = 1'b1;
    clear_log();
    bus.req_addr = {32'h3000, 32'h2000, 32'h1000}; bus.req_valid = 3'b111;
    repeat (16) tick();
    chk_log("fair wave1", 32'h1000, 32'h2000, 32'h3000, 3);
    clear_log();
    bus.req_addr = {32'h3004, 32'h2004, 32'h1004}; bus.req_valid = 3'b111;
    repeat (16) tick();
    chk_log("fair wave2", 32'h1004, 32'h2004, 32'h3004, 3);

    // Write from requester 1
    clear_log();
    bus.req_valid = 3'b010; bus.req_addr[63:32] = 32'h40;
    bus.req_wdata[63:32] = 32'h1234_5678; bus.req_wstrb[7:4] = 4'b0011;
    tick();
    chk("write mv",    bus.memory_valid, 1'b1);
    chk("write wdata", bus.memory_wdata, 32'h1234_5678);
    chk("write wstrb", bus.memory_wstrb, 4'b0011);
    repeat (6) tick();
    chk("write ready pulses", ready_cnt[1], 1);

    // Timeout on requester 2, then a late ready, then a normal request
    auto_ready = 0;
    bus.req_wstrb = '0;
    bus.req_valid = 3'b100; bus.req_addr[95:64] = 32'h9000;
    tick();
    c = 1; found = 0;
    while (c < 30 && !found) begin
      tick(); c++;
      if (bus.req_ready[2]) found = 1;
    end
    chk("timeout cycle", c, 11);
    chk("timeout error", bus.req_error[2], 1'b1);
    chk("timeout rdata", bus.req_rdata[95:64], 32'h0);
    bus.memory_ready = 1'b1; bus.memory_rdata = 32'h5555_5555;
    tick();
    chk("late ready ignored", bus.req_ready, 3'b000);
    auto_ready = 1;
    clear_log();
    bus.req_valid = 3'b100; bus.req_addr[95:64] = 32'h9004;
    repeat (8) tick();
    chk("after timeout pulses", ready_cnt[2], 1);
    chk("after timeout errors", err_cnt, 0);

    // Overlap and duplicate pulse
    clear_log();
    bus.req_valid = 3'b001; bus.req_addr[31:0] = 32'h500;
    tick();
    bus.req_valid = 3'b010; bus.req_addr[63:32] = 32'h600;
    tick();
    bus.req_valid = 3'b010; bus.req_addr[63:32] = 32'h700;
    tick();
    repeat (15) tick();
    chk_log("overlap", 32'h500, 32'h600, 32'h0, 2);
    chk("overlap req0 pulses", ready_cnt[0], 1);
    chk("overlap req1 pulses", ready_cnt[1], 1);

    // Reset while waiting on the slave
    auto_ready = 0;
    clear_log();
    bus.req_valid = 3'b001; bus.req_addr[31:0] = 32'h800;
    tick(); tick(); tick();
    reset = 1'b0;
    tick();
    chk("midreset memory_valid", bus.memory_valid, 1'b0);
    chk("midreset memory_addr",  bus.memory_addr, 32'h0);
    chk("midreset memory_wdata", bus.memory_wdata, 32'h0);
    chk("midreset req_rdata",    bus.req_rdata, 96'h0);
    reset = 1'b1;
    bus.memory_ready = 1'b1; bus.memory_rdata = 32'h1234;
    tick();
    repeat (5) tick();
    chk("midreset no response", ready_cnt[0], 0);
    chk("midreset rdata after", bus.req_rdata, 96'h0);

    // Random traffic against the model
    for (int r = 0; r < 3000; r++) begin
      reset = ($urandom_range(0, 399) != 0);
      for (int i = 0; i < N; i++) begin
        bus.req_valid[i]          = ($urandom_range(0, 99) < 15);
        bus.req_instr[i]          = 1'($urandom);
        bus.req_addr[32*i +: 32]  = $urandom;
        bus.req_wdata[32*i +: 32] = $urandom;
        bus.req_wstrb[4*i +: 4]   = 4'($urandom);
      end
      bus.memory_ready = ($urandom_range(0, 99) < (((r / 250) % 2) != 0 ? 3 : 40));
      bus.memory_rdata = $urandom;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
